// File: rtl/fixed_point_iterative_mac.sv
// Iterative shift-add fixed-point multiply-accumulate behind a val/rdy stream interface.
// Optional build macro FIXED_POINT_MAC_SATURATE_EN clamps c to the representable range on overflow.
module fixed_point_iterative_mac #(
  parameter int unsigned n    = 8,
  parameter int unsigned d    = 4,
  parameter int unsigned sign = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         acc_en,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] c,
  output logic         ovf
);

  localparam int unsigned AW = 2 * n;
  localparam int unsigned CW = $clog2(n);
  localparam int unsigned HW = n - d + 1;
  localparam int unsigned UW = n - d;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   mcand;
  logic [n-1:0]    mplier;
  logic [CW-1:0]   cnt;

  logic [AW-1:0]   term_c;
  logic            last_c;
  logic [AW-1:0]   acc_nxt_c;
  logic [HW-1:0]   top_s_c;
  logic [UW-1:0]   top_u_c;
  logic            ovf_c;
  logic [n-1:0]    res_c;

  // One partial product per cycle; the multiplier MSB carries negative weight when signed.
  always_comb begin
    term_c    = mplier[0] ? mcand : '0;
    last_c    = (cnt == CW'(n - 1));
    acc_nxt_c = (last_c && (sign != 0)) ? acc - term_c : acc + term_c;
    top_s_c   = acc_nxt_c[AW-1:n+d-1];
    top_u_c   = acc_nxt_c[AW-1:n+d];
    ovf_c     = (sign != 0) ? !((top_s_c == '0) || (top_s_c == '1)) : (top_u_c != '0);
    res_c     = acc_nxt_c[n+d-1:d];
`ifdef FIXED_POINT_MAC_SATURATE_EN
    if (ovf_c) begin
      if (sign == 0)
        res_c = '1;
      else
        res_c = acc_nxt_c[AW-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
    end
`endif
  end

  // Partial products land directly in acc; a non-accumulating op clears it at accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      recv_rdy <= 1'b1;
      send_val <= 1'b0;
      c        <= '0;
      ovf      <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (recv_val) begin
            mcand    <= (sign != 0) ? {{n{a[n-1]}}, a} : {{n{1'b0}}, a};
            mplier   <= b;
            cnt      <= '0;
            if (!acc_en) acc <= '0;
            recv_rdy <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_nxt_c;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last_c) begin
            c        <= res_c;
            ovf      <= ovf_c;
            send_val <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (send_rdy) begin
            send_val <= 1'b0;
            recv_rdy <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_iterative_mac.sv
// Self-checking bench for fixed_point_iterative_mac: signed Q4.4 instance plus an unsigned Q8.0 instance.
module tb_fixed_point_iterative_mac;

  localparam int N   = 8;
  localparam int LAT = 8; // edges after the accept edge until send_val is seen

  logic       clk, reset;
  logic       recv_val, recv_val_u, acc_en, send_rdy;
  logic [7:0] a, b;
  logic       recv_rdy, send_val, ovf;
  logic [7:0] c;
  logic       recv_rdy_u, send_val_u, ovf_u;
  logic [7:0] c_u;

  int total = 0;
  int bad   = 0;
  longint macc   = 0;
  longint macc_u = 0;

  fixed_point_iterative_mac #(.n(8), .d(4), .sign(1)) dut (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .a(a), .b(b), .acc_en(acc_en), .send_val(send_val), .send_rdy(send_rdy),
    .c(c), .ovf(ovf));

  fixed_point_iterative_mac #(.n(8), .d(0), .sign(0)) dut_u (
    .clk(clk), .reset(reset), .recv_val(recv_val_u), .recv_rdy(recv_rdy_u),
    .a(a), .b(b), .acc_en(acc_en), .send_val(send_val_u), .send_rdy(send_rdy),
    .c(c_u), .ovf(ovf_u));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer product, 2n-bit wrapping accumulator, range check on acc/2^d.
  function automatic void ref_mac(input longint acc_in, input int av, input int bv, input bit en,
                                  input int nn, input int dd, input bit sg,
                                  output longint acc_out, output int c_out, output bit ovf_out);
    longint pa, pb, full, s, v, lo, hi, m2, mn;
    m2 = (longint'(1) << (2 * nn)) - 1;
    mn = (longint'(1) << nn) - 1;
    pa = av;
    pb = bv;
    if (sg) begin
      if (pa >= (longint'(1) << (nn - 1))) pa = pa - (longint'(1) << nn);
      if (pb >= (longint'(1) << (nn - 1))) pb = pb - (longint'(1) << nn);
    end
    full = (en ? acc_in + pa * pb : pa * pb) & m2;
    acc_out = full;
    if (sg) begin
      s  = (full >= (longint'(1) << (2 * nn - 1))) ? full - (longint'(1) << (2 * nn)) : full;
      v  = s >>> dd;
      lo = -(longint'(1) << (nn - 1));
      hi = (longint'(1) << (nn - 1)) - 1;
    end else begin
      v  = full >> dd;
      lo = 0;
      hi = mn;
    end
    ovf_out = (v < lo) || (v > hi);
    c_out = int'(v & mn);
`ifdef FIXED_POINT_MAC_SATURATE_EN
    if (ovf_out) c_out = int'(((v < 0) ? lo : hi) & mn);
`endif
  endfunction

  // Drives one request, measures latency, then consumes the result.
  task automatic run_op(input bit u, input logic [7:0] av, input logic [7:0] bv, input bit en,
                        output logic [7:0] oc, output logic oo, output int lat);
    @(negedge clk);
    a = av; b = bv; acc_en = en; send_rdy = 1'b0;
    if (u) recv_val_u = 1'b1; else recv_val = 1'b1;
    @(posedge clk);
    #1;
    recv_val = 1'b0; recv_val_u = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (u ? send_val_u : send_val) begin
        lat = k;
        break;
      end
    end
    oc = u ? c_u : c;
    oo = u ? ovf_u : ovf;
    @(negedge clk);
    send_rdy = 1'b1;
    @(posedge clk);
    #1;
    send_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; recv_val = 0; recv_val_u = 0; acc_en = 0; send_rdy = 0; a = 0; b = 0;
    #12;
    total++; if (send_val !== 1'b0) begin bad++; $display("FAIL reset_send_val got=%b want=0", send_val); end
    total++; if (c !== 8'h00) begin bad++; $display("FAIL reset_c got=%h want=00", c); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++; if (recv_rdy !== 1'b1) begin bad++; $display("FAIL reset_recv_rdy got=%b want=1", recv_rdy); end
    total++; if (recv_rdy_u !== 1'b1) begin bad++; $display("FAIL reset_recv_rdy_u got=%b want=1", recv_rdy_u); end
    macc = 0; macc_u = 0;
  endtask

  task automatic test_directed();
    logic [7:0] va[7] = '{8'h18, 8'hE8, 8'h10, 8'h70, 8'h00, 8'h37, 8'h80};
    logic [7:0] vb[7] = '{8'h20, 8'h20, 8'h10, 8'h20, 8'h5B, 8'h00, 8'h80};
    bit         ve[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef FIXED_POINT_MAC_SATURATE_EN
    logic [7:0] vc[7] = '{8'h30, 8'hD0, 8'hE0, 8'h7F, 8'h00, 8'h00, 8'h7F};
`else
    logic [7:0] vc[7] = '{8'h30, 8'hD0, 8'hE0, 8'hE0, 8'h00, 8'h00, 8'h00};
`endif
    bit         vo[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] oc; logic oo; int lat, ec; bit eo;
    for (int i = 0; i < 7; i++) begin
      ref_mac(macc, int'(va[i]), int'(vb[i]), ve[i], 8, 4, 1'b1, macc, ec, eo);
      run_op(1'b0, va[i], vb[i], ve[i], oc, oo, lat);
      total++; if (oc !== vc[i]) begin bad++; $display("FAIL directed_c[%0d] got=%h want=%h", i, oc, vc[i]); end
      total++; if (oo !== vo[i]) begin bad++; $display("FAIL directed_ovf[%0d] got=%b want=%b", i, oo, vo[i]); end
      total++; if (lat != LAT) begin bad++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, LAT); end
    end
  endtask

  task automatic test_stall();
    logic [7:0] av, bv; int ec, lat; bit eo; bit seen;
    av = 8'($urandom); bv = 8'($urandom);
    ref_mac(macc, int'(av), int'(bv), 1'b0, 8, 4, 1'b1, macc, ec, eo);
    @(negedge clk);
    a = av; b = bv; acc_en = 1'b0; send_rdy = 1'b0; recv_val = 1'b1;
    @(posedge clk);
    #1 recv_val = 1'b0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk);
      #1 seen = send_val;
    end
    total++; if (!seen) begin bad++; $display("FAIL stall_timeout got=0 want=1"); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      recv_val = 1'b1; a = 8'($urandom); b = 8'($urandom); acc_en = 1'($urandom);
      @(posedge clk);
      #1;
      total++; if (send_val !== 1'b1) begin bad++; $display("FAIL stall_send_val got=%b want=1", send_val); end
      total++; if (c !== 8'(ec)) begin bad++; $display("FAIL stall_c got=%h want=%h", c, 8'(ec)); end
      total++; if (ovf !== eo) begin bad++; $display("FAIL stall_ovf got=%b want=%b", ovf, eo); end
      total++; if (recv_rdy !== 1'b0) begin bad++; $display("FAIL stall_recv_rdy got=%b want=0", recv_rdy); end
    end
    @(negedge clk);
    recv_val = 1'b0; send_rdy = 1'b1;
    @(posedge clk);
    #1 send_rdy = 1'b0;
    total++; if (send_val !== 1'b0 || recv_rdy !== 1'b1) begin
      bad++; $display("FAIL stall_release got=%b%b want=01", send_val, recv_rdy);
    end
    // The next op accumulates onto the stalled result; ignored requests must not have touched acc.
    av = 8'h08; bv = 8'h10;
    ref_mac(macc, int'(av), int'(bv), 1'b1, 8, 4, 1'b1, macc, ec, eo);
    begin
      logic [7:0] oc; logic oo;
      run_op(1'b0, av, bv, 1'b1, oc, oo, lat);
      total++; if (oc !== 8'(ec)) begin bad++; $display("FAIL stall_next_c got=%h want=%h", oc, 8'(ec)); end
    end
  endtask

  task automatic test_random();
    logic [7:0] av, bv, oc; logic oo; bit en, eo; int ec, lat;
    for (int i = 0; i < 40; i++) begin
      av = 8'($urandom); bv = 8'($urandom); en = 1'($urandom);
      if (i % 10 == 3) av = 8'h80;
      if (i % 10 == 7) bv = 8'h80;
      ref_mac(macc, int'(av), int'(bv), en, 8, 4, 1'b1, macc, ec, eo);
      run_op(1'b0, av, bv, en, oc, oo, lat);
      total++; if (oc !== 8'(ec) || oo !== eo || lat != LAT) begin
        bad++;
        $display("FAIL random[%0d] a=%h b=%h en=%b got c=%h ovf=%b lat=%0d want c=%h ovf=%b lat=%0d",
                 i, av, bv, en, oc, oo, lat, 8'(ec), eo, LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    int hits[3]; logic [7:0] got[3]; int ec[3]; bit eo; int nh;
    for (int i = 0; i < 3; i++) ref_mac(macc, 8'h08, 8'h10, 1'b1, 8, 4, 1'b1, macc, ec[i], eo);
    @(negedge clk);
    a = 8'h08; b = 8'h10; acc_en = 1'b1; recv_val = 1'b1; send_rdy = 1'b1;
    nh = 0;
    for (int k = 1; k <= 60 && nh < 3; k++) begin
      @(posedge clk);
      #1;
      if (send_val) begin
        hits[nh] = k; got[nh] = c; nh++;
        if (nh == 3) recv_val = 1'b0;
      end
    end
    recv_val = 1'b0;
    @(negedge clk);
    send_rdy = 1'b0;
    total++; if (nh != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", nh); end
    for (int i = 0; i < 3 && i < nh; i++) begin
      total++; if (got[i] !== 8'(ec[i])) begin bad++; $display("FAIL b2b_c[%0d] got=%h want=%h", i, got[i], 8'(ec[i])); end
    end
    for (int i = 1; i < 3 && i < nh; i++) begin
      total++; if (hits[i] - hits[i-1] != N + 2) begin
        bad++; $display("FAIL b2b_interval[%0d] got=%0d want=%0d", i, hits[i] - hits[i-1], N + 2);
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [7:0] oc; logic oo; int lat, ec; bit eo, rose;
    @(negedge clk);
    a = 8'h30; b = 8'h50; acc_en = 1'b0; recv_val = 1'b1; send_rdy = 1'b1;
    @(posedge clk);
    #1 recv_val = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    macc = 0; macc_u = 0;
    rose = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1 if (send_val) rose = 1;
    end
    send_rdy = 1'b0;
    total++; if (rose) begin bad++; $display("FAIL midreset_send_val got=1 want=0"); end
    total++; if (recv_rdy !== 1'b1) begin bad++; $display("FAIL midreset_recv_rdy got=%b want=1", recv_rdy); end
    ref_mac(macc, 8'h10, 8'h10, 1'b1, 8, 4, 1'b1, macc, ec, eo);
    run_op(1'b0, 8'h10, 8'h10, 1'b1, oc, oo, lat);
    total++; if (oc !== 8'h10 || oo !== 1'b0) begin bad++; $display("FAIL midreset_next got c=%h ovf=%b want c=10 ovf=0", oc, oo); end
  endtask

  task automatic test_unsigned();
    logic [7:0] oc, av, bv; logic oo; int lat, ec; bit eo, en;
    run_op(1'b1, 8'h0F, 8'h11, 1'b0, oc, oo, lat);
    ref_mac(macc_u, 8'h0F, 8'h11, 1'b0, 8, 0, 1'b0, macc_u, ec, eo);
    total++; if (oc !== 8'hFF || oo !== 1'b0) begin bad++; $display("FAIL unsigned_0f_11 got c=%h ovf=%b want c=ff ovf=0", oc, oo); end
    total++; if (lat != LAT) begin bad++; $display("FAIL unsigned_latency got=%0d want=%0d", lat, LAT); end
    run_op(1'b1, 8'h10, 8'h10, 1'b0, oc, oo, lat);
    ref_mac(macc_u, 8'h10, 8'h10, 1'b0, 8, 0, 1'b0, macc_u, ec, eo);
`ifdef FIXED_POINT_MAC_SATURATE_EN
    total++; if (oc !== 8'hFF || oo !== 1'b1) begin bad++; $display("FAIL unsigned_10_10 got c=%h ovf=%b want c=ff ovf=1", oc, oo); end
`else
    total++; if (oc !== 8'h00 || oo !== 1'b1) begin bad++; $display("FAIL unsigned_10_10 got c=%h ovf=%b want c=00 ovf=1", oc, oo); end
`endif
    for (int i = 0; i < 12; i++) begin
      av = 8'($urandom); bv = 8'($urandom_range(0, 3)); en = 1'($urandom);
      ref_mac(macc_u, int'(av), int'(bv), en, 8, 0, 1'b0, macc_u, ec, eo);
      run_op(1'b1, av, bv, en, oc, oo, lat);
      total++; if (oc !== 8'(ec) || oo !== eo) begin
        bad++; $display("FAIL unsigned_random[%0d] a=%h b=%h en=%b got c=%h ovf=%b want c=%h ovf=%b",
                        i, av, bv, en, oc, oo, 8'(ec), eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_back_to_back();
    test_reset_mid_calc();
    test_unsigned();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
